leading_zero_restore_64: RTL and testbench
==========================================

Name: leading_zero_restore_64

Overview:
- Inverse companion of the 64-bit leading-zero counter: takes a normalized word (MSB = 1) plus its zero count and restores the original un-normalized word by shifting right by that count.
- Used on the de-normalization path after arithmetic on normalized mantissas.
- Iterative log-shifter: processes one count bit per cycle (6 shift cycles).
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 64, data word width; must be a power of two, ≥ 2.
- CW, 6, count width; must equal log2(WIDTH).

Ports:
- i_CLK  input  1  clock; all state updates on the rising edge.
- i_RST_N  input  1  asynchronous active-low reset.
- i_VALID  input  1  input word/count present.
- o_READY  output  1  block can accept an input (IDLE state).
- i_WORD  input  WIDTH  normalized word.
- i_ZERO_COUNT  input  CW  leading-zero count to undo.
- i_INVALID  input  1  source word was all zeros; result forced to 0.
- o_VALID  output  1  result available (DONE state).
- i_READY  input  1  downstream accepts the result.
- o_WORD  output  WIDTH  restored word.
- o_NORM_ERROR  output  1  accepted input had i_WORD[WIDTH-1] = 0 while i_INVALID = 0.

Behaviour:
- Reset (asynchronous, i_RST_N low):
  - State = IDLE.
  - o_VALID = 0, o_READY = 1, o_WORD = 0, o_NORM_ERROR = 0.
  - Internal step counter and count register = 0.
  - Reset asserted mid-operation aborts the operation immediately with no output; the first accept is possible on the edge after i_RST_N is released.
- States:
  - IDLE: o_READY = 1. On an edge with i_VALID = 1:
    - Capture the shift register = (i_INVALID ? 0 : i_WORD).
    - Capture count = i_ZERO_COUNT and step = 0.
    - Capture the error flag = ~i_INVALID & ~i_WORD[WIDTH-1].
    - Go to SHIFT.
  - SHIFT: o_READY = 0. Each edge:
    - If count[step] = 1, shift register >>= (1 << step), logical, zero fill.
    - step increments.
    - On the edge where step = CW-1, go to DONE.
  - DONE: o_VALID = 1; o_WORD = shift register; o_NORM_ERROR = captured flag.
    - On an edge with i_READY = 1, go to IDLE.
    - While i_READY = 0, all outputs hold stable.
- Latency:
  - Accept at edge t0; o_VALID high after edge t0+CW (t0+6).
  - Latency is fixed and independent of the count value and of i_INVALID.
- Throughput:
  - One result per CW+2 cycles with i_READY held high (accept, 6 shifts, handoff).
  - No accept in the same cycle as the DONE handoff; o_READY rises the cycle after the handoff.
- o_WORD and o_NORM_ERROR are don't-care while o_VALID = 0, but must be registered (no combinational path from inputs).
- i_VALID in SHIFT/DONE is ignored; the upstream holds its data until o_READY is high.
- Count 0: all shift steps are no-ops; o_WORD = i_WORD.
- Count WIDTH-1 (63): a normalized input yields o_WORD = 1.
- A non-normalized input is still shifted exactly by the count; only the error flag is raised.
- Round-trip property, asserted formally: for any nonzero X, feeding (X << clz(X), clz(X), 0) returns X with o_NORM_ERROR = 0.

Test Plan:
- Reset, then i_VALID=1, i_WORD=0x8000_0000_0000_0000, i_ZERO_COUNT=63, i_INVALID=0 → o_VALID after exactly 6 edges; o_WORD=0x0000_0000_0000_0001; o_NORM_ERROR=0.
- i_WORD=0xF000_0000_0000_00A0, count=4 → o_WORD=0x0F00_0000_0000_000A. Then count=0 with word 0x8123_4567_89AB_CDEF → o_WORD unchanged.
- i_INVALID=1, i_WORD=0xFFFF_FFFF_FFFF_FFFF, count=5 → o_WORD=0; o_NORM_ERROR=0; same 6-cycle latency.
- i_WORD=0x4000_0000_0000_0000, count=1, i_INVALID=0 → o_WORD=0x2000_0000_0000_0000; o_NORM_ERROR=1.
- Backpressure: hold i_READY=0 for 10 cycles in DONE → o_VALID and o_WORD stable, o_READY=0, a new i_VALID is ignored. Release → IDLE the next cycle, o_READY=1.
- Pull i_RST_N low during the 3rd SHIFT cycle → outputs return to reset values asynchronously and no o_VALID pulse appears. A new operation after release completes correctly.

Source files
------------

// File: rtl/leading_zero_restore_64_if.sv
// Handshake and data bundle between the normalization pipeline and the
// leading-zero restore block. The master side is the upstream/downstream
// environment; the slave side is the restore block itself.
interface leading_zero_restore_64_if #(
    parameter int WIDTH = 64,
    parameter int CW    = 6
);

    logic             i_VALID;
    logic             o_READY;
    logic [WIDTH-1:0] i_WORD;
    logic [CW-1:0]    i_ZERO_COUNT;
    logic             i_INVALID;
    logic             o_VALID;
    logic             i_READY;
    logic [WIDTH-1:0] o_WORD;
    logic             o_NORM_ERROR;

    modport master (
        output i_VALID,
        output i_WORD,
        output i_ZERO_COUNT,
        output i_INVALID,
        output i_READY,
        input  o_READY,
        input  o_VALID,
        input  o_WORD,
        input  o_NORM_ERROR
    );

    modport slave (
        input  i_VALID,
        input  i_WORD,
        input  i_ZERO_COUNT,
        input  i_INVALID,
        input  i_READY,
        output o_READY,
        output o_VALID,
        output o_WORD,
        output o_NORM_ERROR
    );

endinterface

// File: rtl/leading_zero_restore_64.sv
// Leading-zero restore: undoes a normalization shift by shifting a
// normalized word right by its recorded zero count. The shift is done as an
// iterative log-shifter, one count bit per cycle, so latency is always CW
// cycles regardless of the count value. All outputs come straight from flops.
module leading_zero_restore_64 #(
    parameter int WIDTH = 64,
    parameter int CW    = 6
) (
    input  logic                     i_CLK,
    input  logic                     i_RST_N,
    leading_zero_restore_64_if.slave bus
);

    // Step counter only needs to reach CW-1; keep at least one bit.
    localparam int SW = (CW > 1) ? $clog2(CW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    step_q,  step_d;
    logic             err_q,   err_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;

    // Next-state logic: capture in IDLE, conditionally halve-shift in SHIFT,
    // hold the result in DONE until downstream takes it.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        count_d = count_q;
        step_d  = step_q;
        err_d   = err_q;
        valid_d = valid_q;
        ready_d = ready_q;

        case (state_q)
            IDLE: begin
                if (bus.i_VALID) begin
                    shift_d = bus.i_INVALID ? '0 : bus.i_WORD;
                    count_d = bus.i_ZERO_COUNT;
                    step_d  = '0;
                    err_d   = ~bus.i_INVALID & ~bus.i_WORD[WIDTH-1];
                    ready_d = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q[step_q]) begin
                    shift_d = shift_q >> (CW'(1) << step_q);
                end
                step_d = step_q + 1'b1;
                if (step_q == SW'(CW - 1)) begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.i_READY) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q <= IDLE;
            shift_q <= '0;
            count_q <= '0;
            step_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            step_q  <= step_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    assign bus.o_READY      = ready_q;
    assign bus.o_VALID      = valid_q;
    assign bus.o_WORD       = shift_q;
    assign bus.o_NORM_ERROR = err_q;

endmodule

// File: tb/tb_leading_zero_restore_64.sv
// Directed bench for leading_zero_restore_64: shift results, error flag,
// fixed latency, backpressure hold and asynchronous abort.
module tb_leading_zero_restore_64;

    logic i_CLK;
    logic i_RST_N;

    int assertion_count = 0;
    int failure_count   = 0;
    int latency;

    leading_zero_restore_64_if #(.WIDTH(64), .CW(6)) bus ();

    leading_zero_restore_64 #(.WIDTH(64), .CW(6)) dut (
        .i_CLK   (i_CLK),
        .i_RST_N (i_RST_N),
        .bus     (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        assertion_count++;
        assert (observed === expected) else begin
            failure_count++;
            $error("[TB] FAIL %s: observed=0x%016h expected=0x%016h", tag, observed, expected);
        end
    endtask

    // Offer one input at a negedge, let it be accepted, then count edges
    // until o_VALID appears (bounded).
    task automatic applyStimulus(input logic [63:0] word, input logic [5:0] count,
                                 input logic inv, output int lat);
        @(negedge i_CLK);
        checkOutput("ready_before_accept", 64'(bus.o_READY), 64'd1);
        bus.i_VALID      = 1'b1;
        bus.i_WORD       = word;
        bus.i_ZERO_COUNT = count;
        bus.i_INVALID    = inv;
        @(negedge i_CLK);
        bus.i_VALID = 1'b0;
        lat = 0;
        while (bus.o_VALID !== 1'b1 && lat < 20) begin
            @(negedge i_CLK);
            lat++;
        end
    endtask

    // Accept the result and confirm the block returns to IDLE next cycle.
    task automatic handOff(input string tag);
        bus.i_READY = 1'b1;
        @(negedge i_CLK);
        bus.i_READY = 1'b0;
        checkOutput({tag, "_valid_after_handoff"}, 64'(bus.o_VALID), 64'd0);
        checkOutput({tag, "_ready_after_handoff"}, 64'(bus.o_READY), 64'd1);
    endtask

    initial begin
        bus.i_VALID      = 1'b0;
        bus.i_WORD       = '0;
        bus.i_ZERO_COUNT = '0;
        bus.i_INVALID    = 1'b0;
        bus.i_READY      = 1'b0;
        i_RST_N          = 1'b0;

        // Reset values
        repeat (3) @(negedge i_CLK);
        checkOutput("rst_valid", 64'(bus.o_VALID), 64'd0);
        checkOutput("rst_ready", 64'(bus.o_READY), 64'd1);
        checkOutput("rst_word",  bus.o_WORD, 64'd0);
        checkOutput("rst_err",   64'(bus.o_NORM_ERROR), 64'd0);
        i_RST_N = 1'b1;

        // Count 63 on a normalized word leaves only the LSB
        applyStimulus(64'h8000_0000_0000_0000, 6'd63, 1'b0, latency);
        checkOutput("c63_latency", 64'(latency), 64'd6);
        checkOutput("c63_word", bus.o_WORD, 64'h0000_0000_0000_0001);
        checkOutput("c63_err", 64'(bus.o_NORM_ERROR), 64'd0);
        checkOutput("c63_ready_in_done", 64'(bus.o_READY), 64'd0);
        handOff("c63");

        // Count 4, then backpressure for 10 cycles with a new input offered
        applyStimulus(64'hF000_0000_0000_00A0, 6'd4, 1'b0, latency);
        checkOutput("c4_latency", 64'(latency), 64'd6);
        checkOutput("c4_word", bus.o_WORD, 64'h0F00_0000_0000_000A);
        checkOutput("c4_err", 64'(bus.o_NORM_ERROR), 64'd0);
        bus.i_VALID      = 1'b1;
        bus.i_WORD       = 64'hFFFF_0000_FFFF_0000;
        bus.i_ZERO_COUNT = 6'd9;
        for (int i = 0; i < 10; i++) begin
            @(negedge i_CLK);
            checkOutput("bp_valid", 64'(bus.o_VALID), 64'd1);
            checkOutput("bp_word",  bus.o_WORD, 64'h0F00_0000_0000_000A);
            checkOutput("bp_ready", 64'(bus.o_READY), 64'd0);
            checkOutput("bp_err",   64'(bus.o_NORM_ERROR), 64'd0);
        end
        bus.i_VALID = 1'b0;
        handOff("bp");

        // Count 0 passes the word through unchanged
        applyStimulus(64'h8123_4567_89AB_CDEF, 6'd0, 1'b0, latency);
        checkOutput("c0_latency", 64'(latency), 64'd6);
        checkOutput("c0_word", bus.o_WORD, 64'h8123_4567_89AB_CDEF);
        checkOutput("c0_err", 64'(bus.o_NORM_ERROR), 64'd0);
        handOff("c0");

        // Invalid source forces zero, no error, same latency
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 6'd5, 1'b1, latency);
        checkOutput("inv_latency", 64'(latency), 64'd6);
        checkOutput("inv_word", bus.o_WORD, 64'd0);
        checkOutput("inv_err", 64'(bus.o_NORM_ERROR), 64'd0);
        handOff("inv");

        // Non-normalized input is still shifted, error flag raised
        applyStimulus(64'h4000_0000_0000_0000, 6'd1, 1'b0, latency);
        checkOutput("nn_latency", 64'(latency), 64'd6);
        checkOutput("nn_word", bus.o_WORD, 64'h2000_0000_0000_0000);
        checkOutput("nn_err", 64'(bus.o_NORM_ERROR), 64'd1);
        handOff("nn");

        // Round trip: X = 0x12345 has 47 leading zeros
        applyStimulus(64'h91A2_8000_0000_0000, 6'd47, 1'b0, latency);
        checkOutput("rt_latency", 64'(latency), 64'd6);
        checkOutput("rt_word", bus.o_WORD, 64'h0000_0000_0001_2345);
        checkOutput("rt_err", 64'(bus.o_NORM_ERROR), 64'd0);
        handOff("rt");

        // Reset during the third SHIFT cycle aborts with no output
        @(negedge i_CLK);
        bus.i_VALID      = 1'b1;
        bus.i_WORD       = 64'h4000_0000_0000_0000;
        bus.i_ZERO_COUNT = 6'd2;
        bus.i_INVALID    = 1'b0;
        @(negedge i_CLK);
        bus.i_VALID = 1'b0;
        repeat (2) @(negedge i_CLK);
        #2 i_RST_N = 1'b0;
        #1;
        checkOutput("abort_valid", 64'(bus.o_VALID), 64'd0);
        checkOutput("abort_ready", 64'(bus.o_READY), 64'd1);
        checkOutput("abort_word",  bus.o_WORD, 64'd0);
        checkOutput("abort_err",   64'(bus.o_NORM_ERROR), 64'd0);
        repeat (2) @(negedge i_CLK);
        i_RST_N = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge i_CLK);
            checkOutput("post_abort_valid", 64'(bus.o_VALID), 64'd0);
            checkOutput("post_abort_ready", 64'(bus.o_READY), 64'd1);
        end

        // Operation after the abort completes normally
        applyStimulus(64'hC000_0000_0000_0003, 6'd2, 1'b0, latency);
        checkOutput("after_latency", 64'(latency), 64'd6);
        checkOutput("after_word", bus.o_WORD, 64'h3000_0000_0000_0000);
        checkOutput("after_err", 64'(bus.o_NORM_ERROR), 64'd0);
        handOff("after");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertion_count, failure_count);
        $finish;
    end

endmodule
